// File: rtl/ir_dual_dispatch.sv
// Dual-slot dispatch controller between the IR-stage instruction queue and rename.
// Looks at the two oldest queue entries each cycle and pops 0, 1 or 2 of them.
// It accounts for intra-pair RAW, free physical registers, serializing instructions
// and rename back-pressure, and keeps three performance counters.
module ir_dual_dispatch #(
  parameter int PAYLOAD_W = 64,
  parameter int FREE_W    = 7,
  parameter int CNT_W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic [1:0]             q_valid_i,
  input  logic [2*PAYLOAD_W-1:0] q_payload_i,
  input  logic [9:0]             q_rd_i,
  input  logic [9:0]             q_rs1_i,
  input  logic [9:0]             q_rs2_i,
  input  logic [1:0]             q_use_rs1_i,
  input  logic [1:0]             q_use_rs2_i,
  input  logic [1:0]             q_regwrite_i,
  input  logic [1:0]             q_serial_i,
  input  logic [FREE_W-1:0]      free_regs_i,
  input  logic                   backend_empty_i,
  input  logic                   stall_i,
  output logic [1:0]             read_head_o,
  output logic [1:0]             out_valid_o,
  output logic [2*PAYLOAD_W-1:0] out_payload_o,
  output logic [9:0]             out_rd_o,
  output logic [1:0]             out_alloc_o,
  output logic [CNT_W-1:0]       dual_cnt_o,
  output logic [CNT_W-1:0]       single_cnt_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_POST  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       need;
  logic [1:0]       read_head;
  logic [1:0]       out_valid_q, out_valid_d;
  logic             out_empty;
  logic             accept;
  logic             raw;
  logic             run_issue;
  logic [FREE_W:0]  free_ext, need0_ext, need1_ext, need_sum;
  logic             fit0, fit01;
  logic [CNT_W-1:0] dual_cnt_q, dual_cnt_d;
  logic [CNT_W-1:0] single_cnt_q, single_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign out_empty = (out_valid_q == 2'b00);
  assign accept    = out_empty | ~stall_i;

  // Slot 1 reads the register slot 0 writes; x0 writes never count (need[0] is 0).
  assign raw = need[0] &
               ((q_use_rs1_i[1] & (q_rs1_i[9:5] == q_rd_i[4:0])) |
                (q_use_rs2_i[1] & (q_rs2_i[9:5] == q_rd_i[4:0])));

  // One extra bit so the pair's demand can never wrap against the free count.
  assign free_ext  = {1'b0, free_regs_i};
  assign need0_ext = {{FREE_W{1'b0}}, need[0]};
  assign need1_ext = {{FREE_W{1'b0}}, need[1]};
  assign need_sum  = need0_ext + need1_ext;
  assign fit0      = (free_ext >= need0_ext);
  assign fit01     = (free_ext >= need_sum);

  // Issue decision and next FSM state; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    read_head = 2'b00;
    run_issue = 1'b0;
    if (flush_i) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: run_issue = 1'b1;
        ST_DRAIN: begin
          if (out_empty & backend_empty_i & q_valid_i[0] & fit0) begin
            read_head = 2'b01;
            state_d   = ST_POST;
          end
        end
        ST_POST: begin
          // Serial instruction has left the backend: resume normal issue this cycle.
          if (out_empty & backend_empty_i) begin
            state_d   = ST_RUN;
            run_issue = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
      if (run_issue) begin
        if (q_valid_i[0] & q_serial_i[0]) begin
          state_d = ST_DRAIN;
        end else begin
          read_head[0] = q_valid_i[0] & accept & fit0;
          read_head[1] = read_head[0] & q_valid_i[1] & ~q_serial_i[1] & ~raw & fit01;
        end
      end
    end
  end

  assign read_head_o = read_head;

  // Output-stage valid loads the pop pattern whenever the stage can take new data.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush_i) begin
      out_valid_d = 2'b00;
    end else if (accept) begin
      out_valid_d = read_head;
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_slot
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [4:0]           rd_q, rd_d;
    logic                 alloc_q, alloc_d;
    logic                 load;

    assign need[gi] = q_regwrite_i[gi] & (q_rd_i[gi*5 +: 5] != 5'd0);
    assign load     = ~flush_i & accept & read_head[gi];

    // Capture the popped instruction's data; unpopped slots keep their old contents.
    always_comb begin
      payload_d = payload_q;
      rd_d      = rd_q;
      alloc_d   = alloc_q;
      if (~flush_i & accept) begin
        alloc_d = read_head[gi] & need[gi];
      end
      if (load) begin
        payload_d = q_payload_i[gi*PAYLOAD_W +: PAYLOAD_W];
        rd_d      = q_rd_i[gi*5 +: 5];
      end
    end

    // Per-slot output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        payload_q <= '0;
        rd_q      <= '0;
        alloc_q   <= 1'b0;
      end else begin
        payload_q <= payload_d;
        rd_q      <= rd_d;
        alloc_q   <= alloc_d;
      end
    end

    assign out_payload_o[gi*PAYLOAD_W +: PAYLOAD_W] = payload_q;
    assign out_rd_o[gi*5 +: 5]                      = rd_q;
    assign out_alloc_o[gi]                          = alloc_q;
  end

  // Performance counters; they wrap naturally and ignore flush.
  always_comb begin
    dual_cnt_d   = dual_cnt_q;
    single_cnt_d = single_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (read_head == 2'b11) dual_cnt_d = dual_cnt_q + CNT_W'(1);
    if (read_head == 2'b01) single_cnt_d = single_cnt_q + CNT_W'(1);
    if (q_valid_i[0] & (read_head == 2'b00) & ~flush_i) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // FSM state, output-stage valid and counters.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_RUN;
      out_valid_q  <= 2'b00;
      dual_cnt_q   <= '0;
      single_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      dual_cnt_q   <= dual_cnt_d;
      single_cnt_q <= single_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign dual_cnt_o   = dual_cnt_q;
  assign single_cnt_o = single_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
